// File: rtl/ramb_pkg.sv
// ramb_pkg: shared widths and FSM state encoding for the SB_RAM40_4K stream reader.
package ramb_pkg;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int RAM_ADDR_W = 11;
   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t RUN   = 2'd1;
   localparam state_t DRAIN = 2'd2;
endpackage

// File: rtl/ramb_skid2.sv
// ramb_skid2: 2-entry in-order valid/ready buffer; head register drives the stream outputs.
module ramb_skid2 #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [DW-1:0] i_din,
   input  logic          i_pop,
   output logic [DW-1:0] o_dout,
   output logic          o_valid,
   output logic [1:0]    o_occ
);
   logic [DW-1:0] r_head;
   logic [DW-1:0] r_tail;
   logic [1:0]    r_occ;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
         // push into head when it is (or is becoming) free, else park in tail
         if (i_push && (r_occ == 2'd0 || (r_occ == 2'd1 && i_pop)))
            r_head <= i_din;
         else if (i_pop && r_occ == 2'd2)
            r_head <= r_tail;
         if (i_push && r_occ == 2'd1 && !i_pop)
            r_tail <= i_din;
      end
   end
   assign o_dout  = r_head;
   assign o_valid = r_occ != 2'd0;
   assign o_occ   = r_occ;
endmodule

// File: rtl/ramb_stream_reader.sv
// ramb_stream_reader: streams LEN words from an SB_RAM40_4K (256x16) starting at BASE.
// Optional RAMB_READER_LOOP_EN adds a LOOP input that restarts the pass after DONE.
module ramb_stream_reader import ramb_pkg::*; #(
   parameter int AW = ramb_pkg::AW,
   parameter int DW = ramb_pkg::DW
) (
   input  logic                  CLKIN,
   input  logic                  RESET,
   input  logic                  START,
   input  logic [AW-1:0]         BASE,
   input  logic [AW:0]           LEN,
`ifdef RAMB_READER_LOOP_EN
   input  logic                  LOOP,
`endif
   output logic                  BUSY,
   output logic                  DONE,
   output logic [RAM_ADDR_W-1:0] RADDR,
   output logic                  RE,
   output logic                  RCLKE,
   input  logic [DW-1:0]         RDATA,
   output logic [DW-1:0]         DOUT,
   output logic                  DOUT_VALID,
   input  logic                  DOUT_READY
);
   state_t        r_state;
   logic [AW-1:0] r_base;
   logic [AW:0]   r_len;
   logic [AW-1:0] r_addr;
   logic [AW:0]   r_issue;
   logic [AW:0]   r_xfer;
   logic          r_inflight;
   logic          r_zdone;
   logic          w_pop;
   logic          w_last;
   logic          w_loop;
   logic [1:0]    w_occ;
`ifdef RAMB_READER_LOOP_EN
   assign w_loop = LOOP;
`else
   assign w_loop = 1'b0;
`endif
   assign w_pop  = DOUT_VALID & DOUT_READY;
   assign w_last = w_pop && r_xfer == {{AW{1'b0}}, 1'b1};
   // the read in flight counts as an occupied slot so the buffer can never overflow
   assign RE     = r_state == RUN && r_issue != '0 &&
                   ({1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop}) < 3'd2;
   assign RADDR  = {{(RAM_ADDR_W-AW){1'b0}}, r_addr};
   assign RCLKE  = 1'b1;
   assign BUSY   = r_state != IDLE;
   assign DONE   = w_last | r_zdone;
   always_ff @(posedge CLKIN or posedge RESET) begin
      if (RESET) begin
         r_state    <= IDLE;
         r_base     <= '0;
         r_len      <= '0;
         r_addr     <= '0;
         r_issue    <= '0;
         r_xfer     <= '0;
         r_inflight <= 1'b0;
         r_zdone    <= 1'b0;
      end else begin
         r_inflight <= RE;
         r_zdone    <= 1'b0;
         if (RE) begin
            r_addr  <= r_addr + 1'b1;
            r_issue <= r_issue - 1'b1;
         end
         if (w_pop)
            r_xfer <= r_xfer - 1'b1;
         if (r_state == IDLE && START) begin
            r_base  <= BASE;
            r_len   <= LEN;
            r_zdone <= LEN == '0;
            if (LEN != '0) begin
               r_state <= RUN;
               r_addr  <= BASE;
               r_issue <= LEN;
               r_xfer  <= LEN;
            end
         end else if (r_state == RUN && RE && r_issue == {{AW{1'b0}}, 1'b1}) begin
            r_state <= DRAIN;
         end else if (w_last) begin
            r_state <= w_loop ? RUN : IDLE;
            if (w_loop) begin
               r_addr  <= r_base;
               r_issue <= r_len;
               r_xfer  <= r_len;
            end
         end
      end
   end
   ramb_skid2 #(.DW(DW)) u_buf (
      .clk     (CLKIN),
      .rst     (RESET),
      .i_push  (r_inflight),
      .i_din   (RDATA),
      .i_pop   (w_pop),
      .o_dout  (DOUT),
      .o_valid (DOUT_VALID),
      .o_occ   (w_occ)
   );
endmodule

// File: tb/tb_ramb_stream_reader.sv
// tb_ramb_stream_reader: queue-based model of the read stream checked every cycle, plus literal pins.
module tb_ramb_stream_reader;
   logic        CLKIN = 0, RESET = 1, START = 0, DOUT_READY = 1, loop_in = 0;
   logic [7:0]  BASE = 0;
   logic [8:0]  LEN = 0;
   logic        BUSY, DONE, RE, RCLKE, DOUT_VALID;
   logic [10:0] RADDR;
   logic [15:0] RDATA = 0, DOUT;
   logic [15:0] mem [256];
   int checks = 0, failures = 0, cyc = 0, st_cyc = 0, rem = 0, done_cnt = 0;
   logic chk_en = 0, busy_exp = 0, zero_exp = 0, prev_stall = 0, xf, done_exp;
   logic [15:0] prev_dout;
   logic [7:0]  pass_base;
   logic [8:0]  pass_len;
   logic [7:0]  exp_addr[$];
   logic [15:0] exp_data[$];
   logic [15:0] xf_dat[$];
   logic [7:0]  ra_log[$];
   int          xf_cyc[$], re_cyc[$];

   ramb_stream_reader dut (
      .CLKIN(CLKIN), .RESET(RESET), .START(START), .BASE(BASE), .LEN(LEN),
`ifdef RAMB_READER_LOOP_EN
      .LOOP(loop_in),
`endif
      .BUSY(BUSY), .DONE(DONE), .RADDR(RADDR), .RE(RE), .RCLKE(RCLKE), .RDATA(RDATA),
      .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY)
   );

   always #5 CLKIN = ~CLKIN;
   always @(posedge CLKIN) cyc <= cyc + 1;
   always @(posedge CLKIN) if (RE && RCLKE) RDATA <= mem[RADDR[7:0]];

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at cycle %0d", n, got, exp, cyc);
      end
   endtask

   function automatic void load(input logic [7:0] b, input logic [8:0] l);
      for (int i = 0; i < int'(l); i++) begin
         exp_addr.push_back(8'(b + i));
         exp_data.push_back(mem[8'(b + i)]);
      end
      rem = int'(l);
   endfunction

   function automatic logic [31:0] wlog(input int i);
      return xf_dat.size() > i ? {16'h0, xf_dat[i]} : 32'hDEAD;
   endfunction

   function automatic int clog(input int i, input bit re);
      if (re) return re_cyc.size() > i ? re_cyc[i] : -100;
      return xf_cyc.size() > i ? xf_cyc[i] : -100;
   endfunction

   always @(negedge CLKIN) if (chk_en) begin
      chk("rclke", RCLKE, 1);
      chk("busy", BUSY, busy_exp);
      if (RE) begin
         if (exp_addr.size() == 0) chk("re_extra", RE, 0);
         else chk("raddr", RADDR, {3'b000, exp_addr.pop_front()});
         re_cyc.push_back(cyc);
         ra_log.push_back(RADDR[7:0]);
      end
      if (prev_stall) chk("hold", {DOUT_VALID, DOUT}, {1'b1, prev_dout});
      xf = DOUT_VALID && DOUT_READY;
      done_exp = zero_exp || (xf && rem == 1);
      chk("done", DONE, done_exp);
      if (DONE) done_cnt++;
      zero_exp = 0;
      if (xf) begin
         if (exp_data.size() == 0) chk("xf_extra", xf, 0);
         else chk("dout", DOUT, exp_data.pop_front());
         xf_dat.push_back(DOUT);
         xf_cyc.push_back(cyc);
         rem--;
         if (rem == 0) begin
            if (loop_in) load(pass_base, pass_len);
            else busy_exp = 0;
         end
      end
      prev_stall = DOUT_VALID && !DOUT_READY;
      prev_dout  = DOUT;
   end

   task automatic clear_logs();
      xf_dat.delete(); xf_cyc.delete(); re_cyc.delete(); ra_log.delete();
   endtask

   task automatic do_start(input logic [7:0] b, input logic [8:0] l);
      @(posedge CLKIN); #1;
      START = 1; BASE = b; LEN = l; st_cyc = cyc;
      @(posedge CLKIN); #1;
      START = 0;
      if (l == 0) zero_exp = 1;
      else begin
         pass_base = b; pass_len = l; load(b, l); busy_exp = 1;
      end
   endtask

   task automatic wait_done(input int target, input bit tog);
      for (int i = 0; i < 400 && done_cnt < target; i++) begin
         @(posedge CLKIN); #1;
         if (tog) DOUT_READY = ~DOUT_READY;
      end
      DOUT_READY = 1;
      chk("done_timeout", done_cnt >= target, 1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
      #1;
      chk("rst_outs", {BUSY, DONE, DOUT_VALID, RE, RADDR}, 0);
      chk("rst_dout", DOUT, 0);
      repeat (2) @(posedge CLKIN);
      #1 RESET = 0;
      chk_en = 1;

      clear_logs();
      do_start(8'd0, 9'd4);
      wait_done(1, 0);
      chk("t1_re_n", re_cyc.size(), 4);
      chk("t1_re_first", clog(0, 1) - st_cyc, 1);
      chk("t1_re_span", clog(3, 1) - clog(0, 1), 3);
      chk("t1_v_first", clog(0, 0) - st_cyc, 3);
      chk("t1_xf_span", clog(3, 0) - clog(0, 0), 3);
      for (int i = 0; i < 4; i++) chk("t1_word", wlog(i), 32'hA500 + i);

      clear_logs();
      do_start(8'd254, 9'd4);
      wait_done(2, 0);
      chk("t2_addr0", ra_log.size() > 0 ? ra_log[0] : 8'h11, 8'd254);
      chk("t2_addr2", ra_log.size() > 2 ? ra_log[2] : 8'h11, 8'd0);
      chk("t2_w0", wlog(0), 32'hA5FE);
      chk("t2_w1", wlog(1), 32'hA5FF);
      chk("t2_w2", wlog(2), 32'hA500);
      chk("t2_w3", wlog(3), 32'hA501);

      clear_logs();
      do_start(8'd16, 9'd8);
      DOUT_READY = 0;
      wait_done(3, 1);
      chk("t3_count", xf_dat.size(), 8);
      for (int i = 0; i < 8; i++) chk("t3_word", wlog(i), 32'hA510 + i);

      clear_logs();
      do_start(8'd7, 9'd0);
      repeat (3) @(posedge CLKIN);
      #1 chk("t4_zero_done", done_cnt, 4);
      chk("t4_zero_re", re_cyc.size(), 0);
      do_start(8'd40, 9'd4);
      @(posedge CLKIN); #1;
      START = 1; BASE = 8'd99; LEN = 9'd3;
      @(posedge CLKIN); #1;
      START = 0;
      wait_done(5, 0);
      repeat (4) @(posedge CLKIN);
      #1 chk("t4_ign_n", xf_dat.size(), 4);
      chk("t4_ign_w0", wlog(0), 32'hA528);

      clear_logs();
      do_start(8'd0, 9'd8);
      for (int i = 0; i < 100 && xf_dat.size() < 3; i++) begin @(posedge CLKIN); #1; end
      chk_en = 0;
      RESET = 1;
      #1 chk("t5_rst_outs", {BUSY, DONE, DOUT_VALID, RE, RADDR}, 0);
      chk("t5_rst_dout", DOUT, 0);
      @(posedge CLKIN); #1;
      RESET = 0;
      exp_addr.delete(); exp_data.delete();
      rem = 0; busy_exp = 0; zero_exp = 0; prev_stall = 0;
      clear_logs();
      chk_en = 1;
      do_start(8'd0, 9'd2);
      wait_done(6, 0);
      chk("t5_w0", wlog(0), 32'hA500);
      chk("t5_w1", wlog(1), 32'hA501);
      chk("t5_n", xf_dat.size(), 2);

`ifdef RAMB_READER_LOOP_EN
      clear_logs();
      loop_in = 1;
      do_start(8'd5, 9'd2);
      wait_done(8, 0);
      loop_in = 0;
      wait_done(9, 0);
      repeat (4) @(posedge CLKIN);
      #1 chk("t6_n", xf_dat.size(), 6);
      for (int i = 0; i < 6; i++) chk("t6_word", wlog(i), 32'hA505 + (i % 2));
`endif

      repeat (3) @(posedge CLKIN);
      #1 chk("final_empty", exp_data.size() + exp_addr.size(), 0);
      chk("final_idle", BUSY, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
